// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: load-use and branch-compare
// interlocks, redirect flush, imem wait and multiply/divide freeze.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   id_rs, id_rt      : source register fields of the ID instruction
//   id_uses_rt        : ID instruction reads rt
//   id_branch         : ID instruction is a branch compared in ID
//   id_branch_taken   : that branch resolved taken
//   id_jump           : ID instruction is a jump
//   id_md_start       : ID instruction is a multiply/divide
//   ex_memread        : EX instruction is a load
//   ex_regwrite       : EX instruction writes a register
//   ex_rd             : EX destination register
//   imem_ready        : fetched instruction valid this cycle
//   pc_enable         : PC update enable
//   ifid_enable       : IF/ID load enable
//   ifid_flush        : IF/ID loads a NOP
//   idex_bubble       : ID/EX loads a NOP
//   md_busy           : multiply/divide freeze in progress
//   stall_cycles      : saturating count of cycles with pc_enable=0
module pipeline_ctrl #(
  parameter int unsigned MD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_branch,
  input  logic        id_branch_taken,
  input  logic        id_jump,
  input  logic        id_md_start,
  input  logic        ex_memread,
  input  logic        ex_regwrite,
  input  logic [4:0]  ex_rd,
  input  logic        imem_ready,
  output logic        pc_enable,
  output logic        ifid_enable,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        md_busy,
  output logic [15:0] stall_cycles
);

  typedef enum logic {
    RUN,
    MD_WAIT
  } state_e;

  localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] stall_q, stall_d;

  logic load_use;
  logic br_haz;
  logic hazard;
  logic redirect;

  always_comb begin
    load_use = ex_memread && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs) ||
                (id_uses_rt && (ex_rd == id_rt)));
    br_haz   = id_branch && ex_regwrite && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs) || (ex_rd == id_rt));
    hazard   = load_use || br_haz;
    redirect = id_branch_taken || id_jump;
  end

  // Priority: reset, freeze, hazard, redirect, imem wait, normal.
  always_comb begin
    pc_enable   = 1'b1;
    ifid_enable = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      pc_enable   = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (state_q == MD_WAIT) begin
      pc_enable   = 1'b0;
      ifid_enable = 1'b0;
      idex_bubble = 1'b1;
    end else if (hazard) begin
      pc_enable   = 1'b0;
      ifid_enable = 1'b0;
      idex_bubble = 1'b1;
    end else if (redirect) begin
      ifid_flush  = 1'b1;
    end else if (!imem_ready) begin
      pc_enable   = 1'b0;
      ifid_flush  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == MD_WAIT) begin
      if (cnt_q == 8'd0) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end else if (id_md_start && !hazard) begin
      state_d = MD_WAIT;
      cnt_d   = MD_LOAD;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_enable && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // Reset forces md_busy low even while the freeze state is still held.
  assign md_busy      = (state_q == MD_WAIT) && !reset;
  assign stall_cycles = stall_q;

endmodule
